// File: rtl/vote_ctrl_pkg.sv
// Shared definitions for the ballot-session controller: state codes,
// default parameter values and the one-hot test used to classify a press.
package vote_ctrl_pkg;

  localparam int N_CAND_DEF   = 3;
  localparam int DEBOUNCE_DEF = 4;
  localparam int TIMEOUT_DEF  = 1000;
  localparam int CNT_W_DEF    = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE       = 3'd0;
  localparam state_t S_ARMED      = 3'd1;
  localparam state_t S_DEBOUNCE   = 3'd2;
  localparam state_t S_COMMIT     = 3'd3;
  localparam state_t S_SPOIL      = 3'd4;
  localparam state_t S_TIMEOUT_ST = 3'd5;
  localparam state_t S_RELEASE    = 3'd6;
  localparam state_t S_CLOSED     = 3'd7;

  // True when exactly one bit is set; callers zero-extend to 32 bits.
  function automatic logic is_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/vote_controller.sv
// Ballot-session controller: one increment pulse per authorised, debounced,
// single-candidate press; spoils multi-presses, expires idle ballots, locks on close.
module vote_controller
  import vote_ctrl_pkg::*;
#(
  parameter int N_CAND   = N_CAND_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CAND-1:0] btn,
  input  logic              arm,
  input  logic              close_poll,
  output logic [N_CAND-1:0] inc,
  output logic              vote_done,
  output logic              invalid,
  output logic              timeout,
  output logic              armed,
  output logic              closed,
  output logic [CNT_W-1:0]  total_votes,
  output logic [CNT_W-1:0]  invalid_count
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int DW = $clog2(DEBOUNCE + 1);

  state_t            state;
  logic [N_CAND-1:0] pattern;
  logic [DW-1:0]     stable_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              close_req;

  logic              close_hit;
  logic              btn_idle;
  logic [DW-1:0]     deb_next;

  assign close_hit = close_req | close_poll;
  assign btn_idle  = (btn == '0);
  assign deb_next  = stable_cnt + DW'(1);

  // The timeout counter is deliberately held (not cleared) while debouncing,
  // so a ballot that bounces back to ARMED keeps its original deadline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pattern       <= '0;
      stable_cnt    <= '0;
      tmo_cnt       <= '0;
      close_req     <= 1'b0;
      total_votes   <= '0;
      invalid_count <= '0;
    end else begin
      if (close_poll) close_req <= 1'b1;

      case (state)
        S_IDLE: begin
          if (close_hit) begin
            state <= S_CLOSED;
          end else if (arm && btn_idle) begin
            state   <= S_ARMED;
            tmo_cnt <= '0;
          end
        end

        S_ARMED: begin
          if (close_hit) begin
            state <= S_CLOSED;
          end else if (!btn_idle) begin
            state      <= S_DEBOUNCE;
            pattern    <= btn;
            stable_cnt <= DW'(1);
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state <= S_TIMEOUT_ST;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        S_DEBOUNCE: begin
          if (close_hit) begin
            state <= S_CLOSED;
          end else if (btn_idle) begin
            state <= S_ARMED;
          end else if (btn != pattern) begin
            pattern    <= btn;
            stable_cnt <= DW'(1);
          end else if (deb_next == DW'(DEBOUNCE)) begin
            state      <= is_one_hot(32'(pattern)) ? S_COMMIT : S_SPOIL;
            stable_cnt <= deb_next;
          end else begin
            stable_cnt <= deb_next;
          end
        end

        S_COMMIT: begin
          if (total_votes != '1) total_votes <= total_votes + CNT_W'(1);
          state <= S_RELEASE;
        end

        S_SPOIL: begin
          if (invalid_count != '1) invalid_count <= invalid_count + CNT_W'(1);
          state <= S_RELEASE;
        end

        S_TIMEOUT_ST: state <= S_IDLE;

        // A close request arriving here is only latched; IDLE acts on it.
        S_RELEASE: begin
          if (btn_idle) state <= S_IDLE;
        end

        S_CLOSED: state <= S_CLOSED;

        default: state <= S_IDLE;
      endcase
    end
  end

  assign inc       = (state == S_COMMIT) ? pattern : '0;
  assign vote_done = (state == S_COMMIT);
  assign invalid   = (state == S_SPOIL);
  assign timeout   = (state == S_TIMEOUT_ST);
  assign armed     = (state == S_ARMED) || (state == S_DEBOUNCE);
  assign closed    = (state == S_CLOSED);

endmodule

// File: tb/tb_vote_controller.sv
// Directed bench for vote_controller with DEBOUNCE=2, TIMEOUT=16; each task
// drives one scenario and checks hand-computed expectations inline.
module tb_vote_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic       arm;
  logic       close_poll;
  logic [2:0] inc;
  logic       vote_done;
  logic       invalid;
  logic       timeout;
  logic       armed;
  logic       closed;
  logic [7:0] total_votes;
  logic [7:0] invalid_count;

  int total = 0;
  int bad   = 0;

  vote_controller #(
    .N_CAND(3), .DEBOUNCE(2), .TIMEOUT(16), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .arm(arm), .close_poll(close_poll),
    .inc(inc), .vote_done(vote_done), .invalid(invalid), .timeout(timeout),
    .armed(armed), .closed(closed), .total_votes(total_votes),
    .invalid_count(invalid_count)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the edge that consumed the inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 3'b000; arm = 1'b0; close_poll = 1'b0;
    step(); step();
    total++;
    if ({inc, vote_done, invalid, timeout, armed, closed} !== 8'd0) begin
      bad++; $display("[TB] FAIL reset_flags got=%b want=00000000",
                      {inc, vote_done, invalid, timeout, armed, closed});
    end
    total++;
    if (total_votes !== 8'd0 || invalid_count !== 8'd0) begin
      bad++; $display("[TB] FAIL reset_counters got=%0d/%0d want=0/0",
                      total_votes, invalid_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_vote();
    int pulses = 0;
    arm = 1'b1; step(); arm = 1'b0;
    total++;
    if (armed !== 1'b1) begin bad++; $display("[TB] FAIL arm_to_armed got=%b want=1", armed); end
    btn = 3'b001;
    step();
    total++;
    if (inc !== 3'b000) begin bad++; $display("[TB] FAIL single_early got=%b want=000", inc); end
    step();
    total++;
    if (inc !== 3'b001 || vote_done !== 1'b1) begin
      bad++; $display("[TB] FAIL single_pulse got inc=%b done=%b want inc=001 done=1", inc, vote_done);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (inc !== 3'b000) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("[TB] FAIL single_extra got=%0d want=0", pulses); end
    total++;
    if (total_votes !== 8'd1) begin bad++; $display("[TB] FAIL single_total got=%0d want=1", total_votes); end
    btn = 3'b000; step();
    // Back in IDLE a fresh arm must be accepted again.
    arm = 1'b1; step(); arm = 1'b0;
    total++;
    if (armed !== 1'b1) begin bad++; $display("[TB] FAIL single_rearm got=%b want=1", armed); end
    btn = 3'b100; step(); step(); btn = 3'b000; step(); step();
  endtask

  task automatic test_spoil();
    int pulses = 0;
    arm = 1'b1; step(); arm = 1'b0;
    btn = 3'b101; step(); step();
    total++;
    if (invalid !== 1'b1 || inc !== 3'b000) begin
      bad++; $display("[TB] FAIL spoil_pulse got invalid=%b inc=%b want 1/000", invalid, inc);
    end
    step();
    total++;
    if (invalid_count !== 8'd1 || invalid !== 1'b0) begin
      bad++; $display("[TB] FAIL spoil_count got=%0d inv=%b want=1/0", invalid_count, invalid);
    end
    btn = 3'b000; step();
    btn = 3'b001;
    for (int i = 0; i < 5; i++) begin
      step();
      if (inc !== 3'b000 || armed !== 1'b0) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("[TB] FAIL spoil_reuse got=%0d want=0", pulses); end
    btn = 3'b000; step();
  endtask

  task automatic test_bounce();
    arm = 1'b1; step(); arm = 1'b0;
    btn = 3'b001; step();
    btn = 3'b000; step();
    total++;
    if (inc !== 3'b000 || armed !== 1'b1) begin
      bad++; $display("[TB] FAIL bounce_mid got inc=%b armed=%b want 000/1", inc, armed);
    end
    btn = 3'b010; step(); step();
    total++;
    if (inc !== 3'b010) begin bad++; $display("[TB] FAIL bounce_pulse got=%b want=010", inc); end
    step();
    total++;
    if (inc !== 3'b000 || total_votes !== 8'd3) begin
      bad++; $display("[TB] FAIL bounce_after got inc=%b total=%0d want 000/3", inc, total_votes);
    end
    btn = 3'b000; step();
  endtask

  task automatic test_timeout();
    int first = -1;
    int count = 0;
    int pulses = 0;
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (timeout === 1'b1) begin
        count++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (count != 1 || first < 14 || first > 15) begin
      bad++; $display("[TB] FAIL timeout_pulse got count=%0d at=%0d want count=1 at=14..15", count, first);
    end
    total++;
    if (armed !== 1'b0) begin bad++; $display("[TB] FAIL timeout_armed got=%b want=0", armed); end
    btn = 3'b010;
    for (int i = 0; i < 4; i++) begin
      step();
      if (inc !== 3'b000) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("[TB] FAIL timeout_late got=%0d want=0", pulses); end
    btn = 3'b000; step();
  endtask

  task automatic test_close();
    int pulses = 0;
    arm = 1'b1; step(); arm = 1'b0;
    close_poll = 1'b1; step(); close_poll = 1'b0;
    total++;
    if (closed !== 1'b1 || armed !== 1'b0 || inc !== 3'b000) begin
      bad++; $display("[TB] FAIL close_armed got closed=%b armed=%b inc=%b want 1/0/000", closed, armed, inc);
    end
    arm = 1'b1; btn = 3'b001;
    for (int i = 0; i < 6; i++) begin
      step();
      if (inc !== 3'b000 || vote_done !== 1'b0 || closed !== 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("[TB] FAIL close_locked got=%0d want=0", pulses); end
    total++;
    if (total_votes !== 8'd3 || invalid_count !== 8'd1) begin
      bad++; $display("[TB] FAIL close_frozen got=%0d/%0d want=3/1", total_votes, invalid_count);
    end
    arm = 1'b0; btn = 3'b000;
    rst = 1'b1; step(); rst = 1'b0;
    total++;
    if (closed !== 1'b0 || total_votes !== 8'd0 || invalid_count !== 8'd0) begin
      bad++; $display("[TB] FAIL close_reset got closed=%b cnt=%0d/%0d want 0/0/0", closed, total_votes, invalid_count);
    end
    arm = 1'b1; close_poll = 1'b1; step(); arm = 1'b0; close_poll = 1'b0;
    total++;
    if (closed !== 1'b1 || armed !== 1'b0) begin
      bad++; $display("[TB] FAIL close_wins got closed=%b armed=%b want 1/0", closed, armed);
    end
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic test_saturation();
    int pulses = 0;
    for (int v = 0; v < 256; v++) begin
      arm = 1'b1; step(); arm = 1'b0;
      btn = 3'b001; step(); step();
      if (inc === 3'b001) pulses++;
      btn = 3'b000; step(); step();
      if (v == 254) begin
        total++;
        if (total_votes !== 8'd255) begin bad++; $display("[TB] FAIL sat_255 got=%0d want=255", total_votes); end
      end
    end
    total++;
    if (pulses != 256) begin bad++; $display("[TB] FAIL sat_pulses got=%0d want=256", pulses); end
    total++;
    if (total_votes !== 8'd255) begin bad++; $display("[TB] FAIL sat_hold got=%0d want=255", total_votes); end
    arm = 1'b1; step(); arm = 1'b0;
    btn = 3'b100; step(); step();
    total++;
    if (inc !== 3'b100) begin bad++; $display("[TB] FAIL rst_commit_pre got=%b want=100", inc); end
    rst = 1'b1; step(); rst = 1'b0;
    total++;
    if ({inc, vote_done, invalid, timeout, armed, closed} !== 8'd0 || total_votes !== 8'd0) begin
      bad++; $display("[TB] FAIL rst_commit got flags=%b total=%0d want 0/0",
                      {inc, vote_done, invalid, timeout, armed, closed}, total_votes);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (inc !== 3'b000) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("[TB] FAIL rst_no_repeat got=%0d want=0", pulses); end
    btn = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single_vote();
    test_spoil();
    test_bounce();
    test_timeout();
    test_close();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
